// File: rtl/flat_io_pkg.sv
// Shared types and sizing helpers for the flat vector serializer/deserializer.
package flat_io_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 8;

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_APPLY  = 2'd1,
        ST_SETTLE = 2'd2,
        ST_SEND   = 2'd3
    } state_e;

    // Number of bytes needed to carry a vector of the given bit width.
    function automatic int unsigned byte_count(input int unsigned bits);
        return (bits + BYTE_W - 1) / BYTE_W;
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/flat_vector_serdes_if.sv
// Host byte streams plus the flattened stimulus/response vectors of the wrapped DUT.
interface flat_vector_serdes_if #(
    parameter int unsigned IN_W  = 8,
    parameter int unsigned OUT_W = 8
);

    logic             s_valid;
    logic             s_ready;
    logic [7:0]       s_data;
    logic [IN_W-1:0]  in_flat;
    logic             apply;
    logic [OUT_W-1:0] out_flat;
    logic             m_valid;
    logic             m_ready;
    logic [7:0]       m_data;

    // Serdes side.
    modport slave (
        input  s_valid, s_data, out_flat, m_ready,
        output s_ready, in_flat, apply, m_valid, m_data
    );

    // Host / wrapped-DUT side.
    modport master (
        output s_valid, s_data, out_flat, m_ready,
        input  s_ready, in_flat, apply, m_valid, m_data
    );

endinterface

// File: rtl/flat_vector_serdes_byte_slicer.sv
// Selects byte idx_i of a response vector, zero padding bits beyond OUT_W.
module byte_slicer
    import flat_io_pkg::*;
#(
    parameter int unsigned OUT_W = 8,
    parameter int unsigned IDX_W = 1
) (
    input  logic [OUT_W-1:0]  vec_i,
    input  logic [IDX_W-1:0]  idx_i,
    output logic [BYTE_W-1:0] byte_c_o
);

    localparam int unsigned PAD_W = byte_count(OUT_W) * BYTE_W;

    // Indices past the last byte shift everything out and yield zero.
    assign byte_c_o = BYTE_W'(PAD_W'(vec_i) >> {idx_i, 3'b000});

endmodule

// File: rtl/flat_vector_serdes.sv
// Loads a stimulus vector byte-wise, applies it to a wrapped DUT, waits, then streams back the response.
module flat_vector_serdes
    import flat_io_pkg::*;
#(
    parameter int unsigned IN_W   = 8,
    parameter int unsigned OUT_W  = 8,
    parameter int unsigned SETTLE = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    flat_vector_serdes_if.slave bus
);

    localparam int unsigned NI          = byte_count(IN_W);
    localparam int unsigned NO          = byte_count(OUT_W);
    localparam int unsigned NMAX        = max_u(NI, NO);
    localparam int unsigned IDX_W       = $clog2(NMAX + 1);
    localparam int unsigned SH_W        = NI * BYTE_W;
    localparam int unsigned SETTLE_LAST = (SETTLE > 0) ? SETTLE - 1 : 0;

    state_e                state_q, state_d;
    logic [IDX_W-1:0]      ld_idx_q, ld_idx_d;
    logic [IDX_W-1:0]      snd_idx_q, snd_idx_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IN_W-1:0]       shadow_q, shadow_d;
    logic [IN_W-1:0]       in_flat_q, in_flat_d;
    logic [OUT_W-1:0]      resp_q, resp_d;
    logic                  apply_q, apply_d;
    logic                  s_ready_q, s_ready_d;
    logic                  m_valid_q, m_valid_d;
    logic [BYTE_W-1:0]     m_data_q, m_data_d;
    logic [BYTE_W-1:0]     slice_c;

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_LOAD;
            ld_idx_q  <= '0;
            snd_idx_q <= '0;
            cnt_q     <= '0;
            shadow_q  <= '0;
            in_flat_q <= '0;
            resp_q    <= '0;
            apply_q   <= 1'b0;
            s_ready_q <= 1'b0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
        end else begin
            state_q   <= state_d;
            ld_idx_q  <= ld_idx_d;
            snd_idx_q <= snd_idx_d;
            cnt_q     <= cnt_d;
            shadow_q  <= shadow_d;
            in_flat_q <= in_flat_d;
            resp_q    <= resp_d;
            apply_q   <= apply_d;
            s_ready_q <= s_ready_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
        end
    end

    // Next-state and registered-output decode.
    always_comb begin
        state_d   = state_q;
        ld_idx_d  = ld_idx_q;
        snd_idx_d = snd_idx_q;
        cnt_d     = cnt_q;
        shadow_d  = shadow_q;
        in_flat_d = in_flat_q;
        resp_d    = resp_q;
        apply_d   = 1'b0;
        s_ready_d = s_ready_q;
        m_valid_d = m_valid_q;

        case (state_q)
            ST_LOAD: begin
                s_ready_d = 1'b1;
                if (bus.s_valid && s_ready_q) begin
                    // Write byte ld_idx_q in place; bits at or above IN_W fall off in the truncation.
                    shadow_d = IN_W'((SH_W'(shadow_q) & ~(SH_W'(8'hFF) << {ld_idx_q, 3'b000}))
                                     | (SH_W'(bus.s_data) << {ld_idx_q, 3'b000}));
                    if (ld_idx_q == IDX_W'(NI - 1)) begin
                        ld_idx_d  = '0;
                        s_ready_d = 1'b0;
                        in_flat_d = shadow_d;
                        apply_d   = 1'b1;
                        state_d   = ST_APPLY;
                    end else begin
                        ld_idx_d = ld_idx_q + IDX_W'(1);
                    end
                end
            end

            ST_APPLY: begin
                if (SETTLE == 0) begin
                    resp_d    = bus.out_flat;
                    snd_idx_d = '0;
                    m_valid_d = 1'b1;
                    state_d   = ST_SEND;
                end else begin
                    cnt_d   = '0;
                    state_d = ST_SETTLE;
                end
            end

            ST_SETTLE: begin
                if (cnt_q == CNT_W'(SETTLE_LAST)) begin
                    resp_d    = bus.out_flat;
                    snd_idx_d = '0;
                    m_valid_d = 1'b1;
                    state_d   = ST_SEND;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_SEND: begin
                if (m_valid_q && bus.m_ready) begin
                    if (snd_idx_q == IDX_W'(NO - 1)) begin
                        snd_idx_d = '0;
                        m_valid_d = 1'b0;
                        s_ready_d = 1'b1;
                        state_d   = ST_LOAD;
                    end else begin
                        snd_idx_d = snd_idx_q + IDX_W'(1);
                    end
                end
            end

            default: begin
                state_d   = ST_LOAD;
                s_ready_d = 1'b0;
                m_valid_d = 1'b0;
            end
        endcase
    end

    // Response byte for the next cycle, chosen from the next-state response and index.
    byte_slicer #(
        .OUT_W (OUT_W),
        .IDX_W (IDX_W)
    ) u_byte_slicer (
        .vec_i    (resp_d),
        .idx_i    (snd_idx_d),
        .byte_c_o (slice_c)
    );

    assign m_data_d = m_valid_d ? slice_c : '0;

    assign bus.s_ready = s_ready_q;
    assign bus.in_flat = in_flat_q;
    assign bus.apply   = apply_q;
    assign bus.m_valid = m_valid_q;
    assign bus.m_data  = m_data_q;

endmodule

// File: doc/flat_vector_serdes.md
FLAT_VECTOR_SERDES -- requirements
Module: flat_vector_serdes

Interface
REQ-001 SHALL have parameter IN_W, default 8, width of the DUT flattened input vector (1..1024).
REQ-002 SHALL have parameter OUT_W, default 8, width of the DUT flattened output vector (1..1024).
REQ-003 SHALL have parameter SETTLE, default 1, cycles between in_flat update and out_flat sample (0..255).
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 s_valid  input  1  host byte valid.
REQ-007 s_ready  output  1  byte accepted when s_valid&&s_ready.
REQ-008 s_data  input  8  host byte; vector bits LSB-first.
REQ-009 in_flat  output  IN_W  registered stimulus to the wrapped DUT.
REQ-010 apply  output  1  one-cycle pulse when in_flat takes a new value.
REQ-011 out_flat  input  OUT_W  DUT response vector.
REQ-012 m_valid  output  1  response byte valid.
REQ-013 m_ready  input  1  sink accepts when m_valid&&m_ready.
REQ-014 m_data  output  8  response byte, LSB-first.

Function
REQ-015 NI = ceil(IN_W/8) bytes per stimulus; NO = ceil(OUT_W/8) bytes per response.
REQ-016 FSM states LOAD, APPLY, SETTLE, SEND; reset state LOAD.
REQ-017 LOAD: s_ready=1; byte k (0-based) written to shadow bits [8k+7:8k]; bits >= IN_W dropped; after byte NI-1 accepted -> APPLY.
REQ-018 APPLY (one cycle): in_flat <= shadow, apply=1, s_ready=0; -> SETTLE if SETTLE>0, else sample out_flat same cycle as SETTLE expiry rule below and -> SEND.
REQ-019 SETTLE: counter counts SETTLE cycles after APPLY; on last, out_flat captured into response register; -> SEND.
REQ-020 SETTLE=0: capture occurs in the cycle after APPLY (in_flat visible to DUT for one full cycle minimum).
REQ-021 SEND: m_valid=1, m_data = response byte j; bits >= OUT_W zero-padded; j advances on handshake; after byte NO-1 accepted -> LOAD with byte index 0.
REQ-022 m_data and m_valid SHALL hold stable while m_valid&&!m_ready.
REQ-023 s_ready=0 in APPLY, SETTLE, SEND; host bytes stall, never dropped.
REQ-024 in_flat holds its value until next APPLY; out_flat changes outside capture cycle ignored.
REQ-025 s_ready and m_valid never both 1 (no overlap of load and send).
REQ-026 Index counters sized $clog2(max(NI,NO)+1); no wrap beyond NI-1/NO-1.

Reset
REQ-027 rst_n low, any state: state=LOAD, byte indices=0, shadow=0, in_flat=0, response=0, apply=0, m_valid=0, s_ready=0 while asserted.
REQ-028 s_ready=1 from first clock edge after rst_n deasserts; partial load or send in progress at reset is discarded.

Structure
REQ-029 State enum and byte-count helper function SHALL live in shared package flat_io_pkg.
REQ-030 Single sub-module byte_slicer (combinational OUT_W->byte select with zero pad) is natural; rest flat.

Verification
REQ-031 IN_W=12, OUT_W=10, SETTLE=2: send 0x34,0x0A -> in_flat=12'hA34, one apply pulse, out_flat=10'h3FF tied -> m_data 0xFF then 0x03.
REQ-032 Same config, send 0x34,0xFA -> in_flat=12'hA34 (upper nibble dropped).
REQ-033 m_ready held low 5 cycles on byte 0 -> m_valid=1, m_data=0xFF stable all 5 cycles; s_ready=0 throughout.
REQ-034 SETTLE=0, IN_W=OUT_W=8, out_flat = in_flat+1 externally: send 0x7F -> response 0x80.
REQ-035 rst_n pulsed low after first of two load bytes -> in_flat=0, no apply; next two bytes 0x01,0x00 -> in_flat=12'h001.
REQ-036 Back-to-back: three stimuli streamed with s_valid held high -> three apply pulses, three responses in order, no byte lost.
